// File: rtl/out_iface_fifo.sv
// Downstream output port: the bus master writes bytes to TBR (BASE_ADDR+1); they are
// buffered in a small FIFO and handed to the consumer over a dav_/rfd handshake.
module out_iface_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'h0120,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        ior_,
  input  logic        iow_,
  output logic [7:0]  data_out,
  output logic        dav_,
  input  logic        rfd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovr;
  logic          iow_q;
  logic          ior_q;
  logic [7:0]    drive_q;
  logic [1:0]    state;

  logic       wr_ev;
  logic       rd_ev;
  logic       full;
  logic       pop;
  logic       push;
  logic       ovr_set;
  logic [7:0] tsr;

  assign wr_ev   = !iow_ && iow_q && (addr == BASE_ADDR + 16'd1);
  assign rd_ev   = !ior_ && ior_q && (addr == BASE_ADDR);
  assign full    = (count == FULL_CNT);
  assign pop     = (state == WAIT_ACK) && !rfd;
  // A pop on the same edge frees the slot, so a write to a full FIFO is still accepted.
  assign push    = wr_ev && (!full || pop);
  assign ovr_set = wr_ev && full && !pop;
  assign tsr     = {5'b0, (count == '0), ovr, !full};

  assign data = (!ior_ && addr == BASE_ADDR) ? drive_q : 8'hzz;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      iow_q   <= 1'b1;
      ior_q   <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovr     <= 1'b0;
      drive_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      iow_q <= iow_;
      ior_q <= ior_;
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (rd_ev) drive_q <= tsr;
      // Overrun on the read edge wins over the read-clear so it is not lost.
      if (ovr_set)    ovr <= 1'b1;
      else if (rd_ev) ovr <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      dav_     <= 1'b1;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0 && rfd) begin
            data_out <= mem[rd_ptr];
            dav_     <= 1'b0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!rfd) begin
            dav_  <= 1'b1;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (rfd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_iface_fifo.sv
// Directed bench for out_iface_fifo: bus master writes/reads plus a consumer on dav_/rfd.
module tb_out_iface_fifo;

  logic        clock = 1'b0;
  logic        reset_;
  logic [15:0] addr;
  logic        ior_;
  logic        iow_;
  logic        rfd;
  logic        drv_en;
  logic [7:0]  drv_val;
  wire  [7:0]  data;
  logic [7:0]  data_out;
  logic        dav_;

  int checks   = 0;
  int failures = 0;
  int falls    = 0;

  assign data = drv_en ? drv_val : 8'hzz;

  out_iface_fifo #(.BASE_ADDR(16'h0120), .DEPTH(4)) dut (
    .clock(clock), .reset_(reset_), .addr(addr), .data(data),
    .ior_(ior_), .iow_(iow_), .data_out(data_out), .dav_(dav_), .rfd(rfd)
  );

  always #5 clock = ~clock;
  always @(negedge dav_) falls++;

  task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
    @(negedge clock);
    addr = a; drv_val = v; drv_en = 1'b1; iow_ = 1'b0;
    @(negedge clock);
    iow_ = 1'b1; drv_en = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
    @(negedge clock);
    addr = a; ior_ = 1'b0;
    @(posedge clock); #1;
    v = data;
    @(negedge clock);
    ior_ = 1'b1; addr = 16'h0000;
  endtask

  // Consumer with rfd already high: wait for dav_ low, hold 2 cycles, drop rfd, wait release.
  task automatic receive(output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    b  = 8'h00;
    @(posedge clock); #1;
    while (dav_ !== 1'b0 && n < 50) begin @(posedge clock); #1; n++; end
    if (dav_ === 1'b0) begin
      b = data_out;
      repeat (2) @(posedge clock);
      @(negedge clock); rfd = 1'b0;
      n = 0;
      @(posedge clock); #1;
      while (dav_ !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
      if (dav_ === 1'b1 && data_out === b) ok = 1'b1;
      @(negedge clock); rfd = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    checks++; if (dav_ !== 1'b1) begin failures++; $display("FAIL reset_dav actual=%b required=1", dav_); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out actual=%h required=00", data_out); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL reset_tsr actual=%h required=05", v); end
  endtask

  task automatic test_delivery();
    logic [7:0] v;
    bit ok;
    int f0;
    f0 = falls;
    rfd = 1'b1;
    bus_write(16'h0121, 8'h01);
    checks++; if (dav_ !== 1'b1) begin failures++; $display("FAIL latency_early actual=%b required=1", dav_); end
    @(posedge clock); #1;
    checks++; if (dav_ !== 1'b0) begin failures++; $display("FAIL latency_dav actual=%b required=0", dav_); end
    checks++; if (data_out !== 8'h01) begin failures++; $display("FAIL latency_byte actual=%h required=01", data_out); end
    receive(v, ok);
    checks++; if (!ok || v !== 8'h01) begin failures++; $display("FAIL deliver_01 actual=%h ok=%0d required=01", v, ok); end
    bus_write(16'h0121, 8'h2C);
    receive(v, ok);
    checks++; if (!ok || v !== 8'h2C) begin failures++; $display("FAIL deliver_2c actual=%h ok=%0d required=2c", v, ok); end
    repeat (5) @(posedge clock);
    checks++; if (falls - f0 !== 2) begin failures++; $display("FAIL deliver_falls actual=%0d required=2", falls - f0); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL deliver_tsr actual=%h required=05", v); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    bit ok;
    rfd = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(16'h0121, 8'hA0 + 8'(i));
    checks++; if (dav_ !== 1'b1) begin failures++; $display("FAIL ovr_dav_idle actual=%b required=1", dav_); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL ovr_tsr1 actual=%h required=02", v); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL ovr_tsr2 actual=%h required=00", v); end
    @(negedge clock); rfd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      receive(v, ok);
      checks++;
      if (!ok || v !== 8'hA0 + 8'(i)) begin
        failures++; $display("FAIL ovr_byte%0d actual=%h ok=%0d required=%h", i, v, ok, 8'hA0 + 8'(i));
      end
    end
    repeat (6) @(posedge clock); #1;
    checks++; if (dav_ !== 1'b1) begin failures++; $display("FAIL ovr_no_a4 actual=%b required=1", dav_); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL ovr_final_tsr actual=%h required=05", v); end
  endtask

  task automatic test_full_pop();
    logic [7:0] v;
    bit ok;
    rfd = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(16'h0121, 8'hB0 + 8'(i));
    @(negedge clock); rfd = 1'b1;
    @(posedge clock); #1;
    checks++; if (dav_ !== 1'b0 || data_out !== 8'hB0) begin
      failures++; $display("FAIL fp_present actual=%b/%h required=0/b0", dav_, data_out); end
    @(negedge clock);
    rfd = 1'b0; addr = 16'h0121; drv_val = 8'hB4; drv_en = 1'b1; iow_ = 1'b0;
    @(posedge clock); #1;
    checks++; if (dav_ !== 1'b1) begin failures++; $display("FAIL fp_ack actual=%b required=1", dav_); end
    @(negedge clock);
    iow_ = 1'b1; drv_en = 1'b0; addr = 16'h0000;
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL fp_tsr actual=%h required=00", v); end
    @(negedge clock); rfd = 1'b1;
    for (int i = 1; i < 5; i++) begin
      receive(v, ok);
      checks++;
      if (!ok || v !== 8'hB0 + 8'(i)) begin
        failures++; $display("FAIL fp_byte%0d actual=%h ok=%0d required=%h", i, v, ok, 8'hB0 + 8'(i));
      end
    end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL fp_final_tsr actual=%h required=05", v); end
  endtask

  task automatic test_ignored();
    logic [7:0] v;
    int f0;
    f0 = falls;
    rfd = 1'b1;
    bus_write(16'h0120, 8'h7E);
    bus_read(16'h0121, v);
    repeat (5) @(posedge clock); #1;
    checks++; if (falls - f0 !== 0 || dav_ !== 1'b1) begin
      failures++; $display("FAIL ign_dav falls=%0d dav=%b required=0/1", falls - f0, dav_); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL ign_tsr actual=%h required=05", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int f0;
    rfd = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(16'h0121, 8'hC0 + 8'(i));
    @(negedge clock); rfd = 1'b1;
    @(posedge clock); #1;
    checks++; if (dav_ !== 1'b0) begin failures++; $display("FAIL rm_present actual=%b required=0", dav_); end
    #2 reset_ = 1'b0;
    #1;
    checks++; if (dav_ !== 1'b1 || data_out !== 8'h00) begin
      failures++; $display("FAIL rm_async actual=%b/%h required=1/00", dav_, data_out); end
    @(negedge clock); reset_ = 1'b1;
    f0 = falls;
    repeat (10) @(posedge clock); #1;
    checks++; if (falls - f0 !== 0 || dav_ !== 1'b1) begin
      failures++; $display("FAIL rm_no_pulse falls=%0d dav=%b required=0/1", falls - f0, dav_); end
    bus_read(16'h0120, v);
    checks++; if (v !== 8'h05) begin failures++; $display("FAIL rm_tsr actual=%h required=05", v); end
  endtask

  initial begin
    reset_ = 1'b0; addr = '0; ior_ = 1'b1; iow_ = 1'b1; rfd = 1'b1;
    drv_en = 1'b0; drv_val = '0;
    test_reset();
    test_delivery();
    test_overrun();
    test_full_pop();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
